branch_cond_decoder: RTL and testbench
======================================

// Module: branch_cond_decoder
// PURPOSE
//  Consumes the one-hot relation flags {gt,lt,eq} made by the magnitude comparer and decodes them into a registered RISC-V branch decision.
//  Accepted funct3 codes: BEQ, BNE, BLT, BGE, BLTU and BGEU.
//  Signed ordering is rebuilt from the operand sign bits.
//  One-stage valid/ready pipeline between the compare path and PC-select logic; carries a sideband tag.
// PARAMETERS
//  TAG_W   4   width of the sideband tag (instruction id), passed through unchanged
//  CNT_W   16  width of each statistics counter (used only when BRANCH_STATS_EN is defined)
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  in_valid   in   1      upstream offers a compare result
//  in_ready   out  1      block can accept; = !out_valid || out_ready
//  flags      in   3      relation flags: [2]=a>b, [1]=a<b, [0]=a==b (unsigned)
//  a_msb      in   1      sign bit of operand a
//  b_msb      in   1      sign bit of operand b
//  funct3     in   3      branch type
//  in_tag     in   TAG_W  sideband id
//  out_valid  out  1      registered result available
//  out_ready  in   1      downstream accepts the result
//  taken      out  1      branch taken
//  illegal    out  1      reserved funct3 (010/011) or flags not exactly one-hot
//  out_tag    out  TAG_W  in_tag captured with the result
// BEHAVIOUR
//  - Reset (async, reset_n=0): out_valid=0, taken=0, illegal=0, out_tag=0, counters=0; in_ready=1 after release.
//  - Capture on in_valid && in_ready: output register loads on that edge; latency 1 cycle.
//  - Hold while out_valid && !out_ready: outputs and tag stay stable; in_ready=0.
//  - Same-edge pop/push (out_valid && out_ready && in_valid): new result replaces old; no bubble.
//  - Pop with no push: out_valid clears.
//  - Unsigned relation: ult=flags[1], ueq=flags[0].
//  - Signed relation: if a_msb!=b_msb then slt=a_msb, else slt=flags[1].
//  - funct3 decode: 000 eq | 001 !eq | 100 slt | 101 !slt | 110 ult | 111 !ult.
//  - Illegal case (010, 011, or flags popcount!=1): taken=0, illegal=1, result still handshaken normally.
//  - No state machine beyond the valid bit: states EMPTY (out_valid=0) and FULL (out_valid=1).
//  - Reset asserted mid-hold drops the pending result; nothing is replayed.
// CONFIGURATION
//  - BRANCH_STATS_EN defined: adds outputs taken_cnt[CNT_W], not_taken_cnt[CNT_W] and illegal_cnt[CNT_W].
//    Each counter increments once per output handshake (out_valid && out_ready) of its category.
//    Counters saturate at all-ones; they do not wrap. Reset clears them to 0.
//  - BRANCH_STATS_EN undefined: no counters and no such ports; all other behaviour identical.
// STRUCTURE
//  - Package branch_pkg:
//      localparams F3_BEQ..F3_BGEU and F3 reserved codes;
//      flag bit indices FLAG_GT=2, FLAG_LT=1, FLAG_EQ=0.
//  - Sub-module branch_cond_eval: combinational {flags,a_msb,b_msb,funct3} -> {taken,illegal}.
//  - Top level: instantiates branch_cond_eval plus the valid/ready register and the optional counters.
// TESTING
//  1. BEQ: flags=001 (eq), funct3=000 -> next cycle out_valid=1, taken=1, illegal=0.
//  2. BLT, signs differ: a_msb=1, b_msb=0, flags=100 (unsigned gt), funct3=100 -> taken=1.
//     Same flags with funct3=110 (BLTU) -> taken=0.
//  3. BGE, same signs: a_msb=b_msb=0, flags=010, funct3=101 -> taken=0.
//     Same flags with funct3=111 (BGEU) -> taken=0.
//  4. Illegal: flags=011 or funct3=010 -> taken=0, illegal=1, handshake completes; illegal_cnt +1 if BRANCH_STATS_EN.
//  5. Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs and out_tag stable.
//     Then out_ready=1 with a new input -> back-to-back transfer, no bubble.
//  6. Reset mid-hold: out_valid=1, drop reset_n asynchronously -> out_valid=0 immediately, counters=0.
//     Stats: drive CNT_W=4 with 20 taken handshakes -> taken_cnt=15 (saturated).

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: funct3 codes, relation flag indices and output-stage state for the branch decoder
package branch_pkg;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_RSV2 = 3'b010;
    localparam logic [2:0] F3_RSV3 = 3'b011;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam int FLAG_GT = 2;
    localparam int FLAG_LT = 1;
    localparam int FLAG_EQ = 0;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stage_e;
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational relation flags + sign bits + funct3 -> taken/illegal
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] flags,
    input  logic       a_msb,
    input  logic       b_msb,
    input  logic [2:0] funct3,
    output logic       taken,
    output logic       illegal
);
    logic onehot, slt, cond;
    always_comb begin
        onehot  = flags[FLAG_GT] ? !(flags[FLAG_LT] | flags[FLAG_EQ]) : (flags[FLAG_LT] ^ flags[FLAG_EQ]);
        // differing signs decide signed order outright; equal signs fall back to the unsigned flag
        slt     = (a_msb != b_msb) ? a_msb : flags[FLAG_LT];
        cond    = (funct3 == F3_BEQ)  ?  flags[FLAG_EQ] :
                  (funct3 == F3_BNE)  ? !flags[FLAG_EQ] :
                  (funct3 == F3_BLT)  ?  slt :
                  (funct3 == F3_BGE)  ? !slt :
                  (funct3 == F3_BLTU) ?  flags[FLAG_LT] :
                  (funct3 == F3_BGEU) ? !flags[FLAG_LT] : 1'b0;
        illegal = !onehot || funct3 == F3_RSV2 || funct3 == F3_RSV3;
        taken   = !illegal && cond;
    end
endmodule

// File: rtl/branch_cond_decoder.sv
// branch_cond_decoder: registered valid/ready branch decision with sideband tag.
// Define BRANCH_STATS_EN to add saturating taken/not-taken/illegal handshake counters.
module branch_cond_decoder
    import branch_pkg::*;
#(
    parameter int TAG_W = 4
`ifdef BRANCH_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       flags,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic [2:0]       funct3,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag
`ifdef BRANCH_STATS_EN
    , output logic [CNT_W-1:0] taken_cnt
    , output logic [CNT_W-1:0] not_taken_cnt
    , output logic [CNT_W-1:0] illegal_cnt
`endif
);
    stage_e state, state_nxt;
    logic   taken_c, illegal_c, push;

    branch_cond_eval u_eval (
        .flags   (flags),
        .a_msb   (a_msb),
        .b_msb   (b_msb),
        .funct3  (funct3),
        .taken   (taken_c),
        .illegal (illegal_c)
    );

    assign out_valid = (state == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign push      = in_valid && in_ready;

    always_comb begin
        state_nxt = in_ready ? (in_valid ? FULL : EMPTY) : state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= EMPTY;
            taken   <= 1'b0;
            illegal <= 1'b0;
            out_tag <= '0;
        end else begin
            state <= state_nxt;
            if (push) begin
                taken   <= taken_c;
                illegal <= illegal_c;
                out_tag <= in_tag;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic pop;
    assign pop = out_valid && out_ready;
    // increment by one unless already all-ones, so counters stick at the top
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            taken_cnt     <= '0;
            not_taken_cnt <= '0;
            illegal_cnt   <= '0;
        end else if (pop) begin
            if (illegal)     illegal_cnt   <= illegal_cnt   + CNT_W'(!(&illegal_cnt));
            else if (taken)  taken_cnt     <= taken_cnt     + CNT_W'(!(&taken_cnt));
            else             not_taken_cnt <= not_taken_cnt + CNT_W'(!(&not_taken_cnt));
        end
    end
`endif
endmodule

// File: tb/tb_branch_cond_decoder.sv
// tb_branch_cond_decoder: vector table, hand sequences and random scoreboard for branch_cond_decoder
module tb_branch_cond_decoder;
    localparam int TAG_W = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       flags = 3'b001;
    logic             a_msb = 1'b0;
    logic             b_msb = 1'b0;
    logic [2:0]       funct3 = 3'b000;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             taken;
    logic             illegal;
    logic [TAG_W-1:0] out_tag;
`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_cnt, not_taken_cnt, illegal_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_cond_decoder #(
        .TAG_W(TAG_W)
`ifdef BRANCH_STATS_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flags     (flags),
        .a_msb     (a_msb),
        .b_msb     (b_msb),
        .funct3    (funct3),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .taken     (taken),
        .illegal   (illegal),
        .out_tag   (out_tag)
`ifdef BRANCH_STATS_EN
        , .taken_cnt     (taken_cnt)
        , .not_taken_cnt (not_taken_cnt)
        , .illegal_cnt   (illegal_cnt)
`endif
    );

    typedef struct {
        logic [2:0] flags;
        logic       a_msb;
        logic       b_msb;
        logic [2:0] funct3;
        logic       exp_taken;
        logic       exp_illegal;
    } vec_t;

    typedef struct {
        logic             taken;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } res_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #4 reset_n = 1'b1;
        step();
    endtask

    // reference: decision read straight from the RISC-V branch definitions
    function automatic res_t model(input logic [2:0] f, input logic am, input logic bm,
                                   input logic [2:0] f3, input logic [TAG_W-1:0] tag);
        res_t r;
        bit a_lt_b_u, a_eq_b, a_lt_b_s, go;
        a_lt_b_u = f[1];
        a_eq_b   = f[0];
        a_lt_b_s = (am && !bm) ? 1'b1 : (!am && bm) ? 1'b0 : a_lt_b_u;
        case (f3)
            3'd0:    go = a_eq_b;
            3'd1:    go = !a_eq_b;
            3'd4:    go = a_lt_b_s;
            3'd5:    go = !a_lt_b_s;
            3'd6:    go = a_lt_b_u;
            3'd7:    go = !a_lt_b_u;
            default: go = 1'b0;
        endcase
        r.illegal = ($countones(f) != 1) || f3 == 3'd2 || f3 == 3'd3;
        r.taken   = r.illegal ? 1'b0 : go;
        r.tag     = tag;
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v >= (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : v + 1;
    endfunction

    vec_t vecs[$];
    res_t q[$];

    initial begin
        vecs = '{
            '{3'b001, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0},
            '{3'b100, 1'b1, 1'b0, 3'b100, 1'b1, 1'b0},
            '{3'b100, 1'b1, 1'b0, 3'b110, 1'b0, 1'b0},
            '{3'b010, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0},
            '{3'b010, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0},
            '{3'b011, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1},
            '{3'b001, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1},
            '{3'b001, 1'b1, 1'b1, 3'b011, 1'b0, 1'b1},
            '{3'b000, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1},
            '{3'b100, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0},
            '{3'b010, 1'b0, 1'b1, 3'b101, 1'b1, 1'b0},
            '{3'b010, 1'b1, 1'b1, 3'b100, 1'b1, 1'b0},
            '{3'b010, 1'b0, 1'b1, 3'b110, 1'b1, 1'b0},
            '{3'b001, 1'b1, 1'b0, 3'b111, 1'b1, 1'b0},
            '{3'b100, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0}
        };

        // reset state
        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_taken", 32'(taken), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_out_tag", 32'(out_tag), 0);
        #3 reset_n = 1'b1;
        step();
        chk("rst_in_ready", 32'(in_ready), 1);
`ifdef BRANCH_STATS_EN
        chk("rst_taken_cnt", 32'(taken_cnt), 0);
`endif

        // vector table, one transfer per cycle
        for (int i = 0; i < vecs.size(); i++) begin
            flags = vecs[i].flags; a_msb = vecs[i].a_msb; b_msb = vecs[i].b_msb;
            funct3 = vecs[i].funct3; in_tag = TAG_W'(i); in_valid = 1'b1; out_ready = 1'b1;
            step();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("vec%0d_taken", i), 32'(taken), 32'(vecs[i].exp_taken));
            chk($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(vecs[i].exp_illegal));
            chk($sformatf("vec%0d_tag", i), 32'(out_tag), i);
        end
        in_valid = 1'b0;
        step();
        chk("pop_no_push_valid", 32'(out_valid), 0);

        // backpressure hold, then back-to-back replacement
        flags = 3'b001; funct3 = 3'b000; in_tag = 4'd5; in_valid = 1'b1; out_ready = 1'b0;
        step();
        chk("bp_load_valid", 32'(out_valid), 1);
        flags = 3'b100; in_tag = 4'd6;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_taken", 32'(taken), 1);
            chk("bp_tag", 32'(out_tag), 5);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 1);
        step();
        chk("b2b_valid", 32'(out_valid), 1);
        chk("b2b_tag", 32'(out_tag), 6);
        chk("b2b_taken", 32'(taken), 0);
        in_valid = 1'b0;
        step();
        chk("b2b_drain", 32'(out_valid), 0);

        // randomized traffic against the queue scoreboard
        do_reset();
        begin
            int tc = 0, nc = 0, ic = 0;
            for (int c = 0; c < 400; c++) begin
                bit exp_ready, pushed, popped;
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
                flags     = ($urandom_range(0, 3) != 0) ? 3'(1 << $urandom_range(0, 2)) : 3'($urandom);
                a_msb     = 1'($urandom); b_msb = 1'($urandom);
                funct3    = 3'($urandom); in_tag = TAG_W'($urandom);
                #1;
                exp_ready = (q.size() == 0) || out_ready;
                chk("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
                chk("rnd_in_ready", 32'(in_ready), 32'(exp_ready));
                if (q.size() != 0) begin
                    chk("rnd_taken", 32'(taken), 32'(q[0].taken));
                    chk("rnd_illegal", 32'(illegal), 32'(q[0].illegal));
                    chk("rnd_tag", 32'(out_tag), 32'(q[0].tag));
                end
`ifdef BRANCH_STATS_EN
                chk("rnd_taken_cnt", 32'(taken_cnt), tc);
                chk("rnd_not_taken_cnt", 32'(not_taken_cnt), nc);
                chk("rnd_illegal_cnt", 32'(illegal_cnt), ic);
`endif
                popped = (q.size() != 0) && out_ready;
                pushed = in_valid && exp_ready;
                if (popped) begin
                    if (q[0].illegal) ic = sat(ic);
                    else if (q[0].taken) tc = sat(tc);
                    else nc = sat(nc);
                    void'(q.pop_front());
                end
                if (pushed) q.push_back(model(flags, a_msb, b_msb, funct3, in_tag));
                step();
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        q.delete();

        // reset asserted while a result is held
        in_valid = 1'b1; out_ready = 1'b0; flags = 3'b011; funct3 = 3'b000; in_tag = 4'd9;
        step();
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_illegal", 32'(illegal), 1);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_valid", 32'(out_valid), 0);
        chk("midreset_tag", 32'(out_tag), 0);
`ifdef BRANCH_STATS_EN
        chk("midreset_illegal_cnt", 32'(illegal_cnt), 0);
        chk("midreset_taken_cnt", 32'(taken_cnt), 0);
`endif
        #3 reset_n = 1'b1;
        step();
        chk("after_reset_valid", 32'(out_valid), 0);
        chk("after_reset_ready", 32'(in_ready), 1);

`ifdef BRANCH_STATS_EN
        // 20 taken handshakes saturate a 4-bit counter
        flags = 3'b001; funct3 = 3'b000; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) step();
        in_valid = 1'b0;
        step();
        chk("sat_taken_cnt", 32'(taken_cnt), 15);
        chk("sat_not_taken_cnt", 32'(not_taken_cnt), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
